// File: rtl/axi_lite_initiator.sv
// AXI-Lite initiator: turns one command at a time into an AXI-Lite
// write (AW+W, B) or read (AR, R) and returns the result on a response
// handshake.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/ready, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb
//                              command request
//   rsp_valid/ready, rsp_rdata, rsp_resp
//                              response (rdata is 0 for writes)
//   busy                       high whenever not IDLE
//   txn_count, err_count       completed and error (resp[1]) counts
//   axi_*                      AXI-Lite initiator channels
module axi_lite_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    busy,
    output logic [15:0]             txn_count,
    output logic [7:0]              err_count,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rvalid,
    output logic                    axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_aw_pend;
    logic                    r_w_pend;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_resp;
    logic [15:0]             r_txn;
    logic [7:0]              r_err;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_enter_rsp;
    logic [1:0] w_new_resp;

    // AW and W each have their own pending flag so they can complete
    // in either order; a flag clears on its own handshake.
    always_comb begin
        w_next      = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        rsp_valid   = 1'b0;
        w_enter_rsp = 1'b0;
        w_new_resp  = 2'b00;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    w_next = cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                axi_awvalid = r_aw_pend;
                axi_wvalid  = r_w_pend;
                if ((!r_aw_pend || axi_awready) &&
                    (!r_w_pend  || axi_wready))
                    w_next = WR_RESP;
            end
            WR_RESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    w_next      = RSP;
                    w_enter_rsp = 1'b1;
                    w_new_resp  = axi_bresp;
                end
            end
            RD_REQ: begin
                axi_arvalid = 1'b1;
                if (axi_arready)
                    w_next = RD_DATA;
            end
            RD_DATA: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    w_next      = RSP;
                    w_enter_rsp = 1'b1;
                    w_new_resp  = axi_rresp;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = cmd_ready && cmd_valid;
    assign w_aw_hs  = axi_awvalid && axi_awready;
    assign w_w_hs   = axi_wvalid && axi_wready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
            r_txn     <= 16'd0;
            r_err     <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_aw_pend <= cmd_write;
                r_w_pend  <= cmd_write;
            end
            if (w_aw_hs)
                r_aw_pend <= 1'b0;
            if (w_w_hs)
                r_w_pend <= 1'b0;
            if (w_enter_rsp) begin
                r_resp  <= w_new_resp;
                r_rdata <= (r_state == RD_DATA) ? axi_rdata : '0;
                r_txn   <= r_txn + 16'd1;
                if (w_new_resp[1] && r_err != 8'hFF)
                    r_err <= r_err + 8'd1;
            end
        end
    end

    assign axi_awaddr = r_addr;
    assign axi_araddr = r_addr;
    assign axi_wdata  = r_wdata;
    assign axi_wstrb  = r_wstrb;
    assign rsp_rdata  = r_rdata;
    assign rsp_resp   = r_resp;
    assign txn_count  = r_txn;
    assign err_count  = r_err;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Directed bench for axi_lite_initiator: the bench plays the AXI-Lite
// responder step by step and checks every output against fixed values.
module tb_axi_lite_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [15:0] txn_count;
    logic [7:0]  err_count;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    int checks = 0;
    int errors = 0;

    axi_lite_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .txn_count(txn_count), .err_count(err_count),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wstrb   = '0;
        rsp_ready   = 1'b0;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bresp   = 2'b00;
        axi_bvalid  = 1'b0;
        axi_arready = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        axi_rvalid  = 1'b0;
    endtask

    task automatic quick_read(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] r);
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_addr    = a;
        axi_arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        axi_arready = 1'b0;
        axi_rvalid  = 1'b1;
        axi_rdata   = d;
        axi_rresp   = r;
        tick();
        axi_rvalid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_resp", rsp_resp, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_err", err_count, 0);
        rst_n = 1'b1;

        // zero-wait write; bvalid held high early must be ignored
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 32'h4;
        cmd_wdata   = 32'hDEADBEEF;
        cmd_wstrb   = 4'hF;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        axi_bvalid  = 1'b1;
        axi_bresp   = 2'b00;
        chk("w1_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFF0;
        cmd_wdata = 32'h0;
        chk("w1_awvalid", axi_awvalid, 1);
        chk("w1_wvalid", axi_wvalid, 1);
        chk("w1_awaddr", axi_awaddr, 32'h4);
        chk("w1_wdata", axi_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", axi_wstrb, 4'hF);
        chk("w1_bready_early", axi_bready, 0);
        chk("w1_busy", busy, 1);
        chk("w1_cmd_ready_busy", cmd_ready, 0);
        tick();
        chk("w1_bready", axi_bready, 1);
        chk("w1_aw_drop", axi_awvalid, 0);
        chk("w1_w_drop", axi_wvalid, 0);
        chk("w1_rsp_early", rsp_valid, 0);
        tick();
        axi_bvalid = 1'b0;
        chk("w1_rsp_valid", rsp_valid, 1);
        chk("w1_rsp_resp", rsp_resp, 0);
        chk("w1_rsp_rdata", rsp_rdata, 0);
        chk("w1_txn", txn_count, 1);
        chk("w1_bready_off", axi_bready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w1_done", rsp_valid, 0);
        chk("w1_idle", cmd_ready, 1);
        idle_inputs();

        // read with arready 3 cycles late
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h8;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("r1_arvalid_hold", axi_arvalid, 1);
            chk("r1_araddr_hold", axi_araddr, 32'h8);
            chk("r1_rready_early", axi_rready, 0);
            tick();
        end
        chk("r1_arvalid_last", axi_arvalid, 1);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        chk("r1_ar_drop", axi_arvalid, 0);
        chk("r1_rready", axi_rready, 1);
        axi_rvalid = 1'b1;
        axi_rdata  = 32'h12345678;
        axi_rresp  = 2'b00;
        tick();
        axi_rvalid = 1'b0;
        axi_rdata  = 32'h0;
        chk("r1_rsp_valid", rsp_valid, 1);
        chk("r1_rdata", rsp_rdata, 32'h12345678);
        chk("r1_resp", rsp_resp, 0);
        chk("r1_txn", txn_count, 2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("r1_idle", cmd_ready, 1);

        // write with awready 4 cycles late, wready immediate
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_addr   = 32'h10;
        cmd_wdata  = 32'hA5A5_0001;
        cmd_wstrb  = 4'h3;
        tick();
        cmd_valid  = 1'b0;
        axi_wready = 1'b1;
        chk("w2_awvalid_c1", axi_awvalid, 1);
        chk("w2_wvalid_c1", axi_wvalid, 1);
        tick();
        axi_wready = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            chk("w2_wvalid_dropped", axi_wvalid, 0);
            chk("w2_awvalid_hold", axi_awvalid, 1);
            chk("w2_awaddr_hold", axi_awaddr, 32'h10);
            chk("w2_bready_early", axi_bready, 0);
            tick();
        end
        chk("w2_awvalid_c5", axi_awvalid, 1);
        axi_awready = 1'b1;
        tick();
        axi_awready = 1'b0;
        chk("w2_aw_drop", axi_awvalid, 0);
        chk("w2_bready", axi_bready, 1);
        tick();
        chk("w2_wait_b", axi_bready, 1);
        chk("w2_no_rsp", rsp_valid, 0);
        axi_bvalid = 1'b1;
        axi_bresp  = 2'b01;
        tick();
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        chk("w2_rsp_valid", rsp_valid, 1);
        chk("w2_resp", rsp_resp, 1);
        chk("w2_txn", txn_count, 3);
        chk("w2_err", err_count, 0);

        // hold the response 10 cycles with a command waiting
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        for (int i = 0; i < 10; i++) begin
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_resp", rsp_resp, 1);
            chk("hold_rdata", rsp_rdata, 0);
            chk("hold_cmd_ready", cmd_ready, 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hold_released", rsp_valid, 0);
        chk("hold_txn", txn_count, 3);

        // error read, then saturate the error counter
        quick_read(32'h30, 32'hCAFE_F00D, 2'b10);
        chk("e1_err", err_count, 1);
        chk("e1_txn", txn_count, 4);
        for (int i = 0; i < 299; i++)
            quick_read(32'h30, 32'h0, 2'b10);
        chk("e300_err_sat", err_count, 255);
        chk("e300_txn", txn_count, 303);

        // reset during WR_REQ abandons the write
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h40;
        cmd_wdata = 32'h1;
        cmd_wstrb = 4'h1;
        tick();
        cmd_valid = 1'b0;
        chk("rr_awvalid", axi_awvalid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rr_awvalid_0", axi_awvalid, 0);
        chk("rr_wvalid_0", axi_wvalid, 0);
        chk("rr_arvalid_0", axi_arvalid, 0);
        chk("rr_bready_0", axi_bready, 0);
        chk("rr_rsp_valid_0", rsp_valid, 0);
        chk("rr_txn_0", txn_count, 0);
        chk("rr_err_0", err_count, 0);
        chk("rr_busy_0", busy, 0);
        chk("rr_cmd_ready", cmd_ready, 1);
        axi_bvalid = 1'b1;
        tick();
        axi_bvalid = 1'b0;
        chk("rr_no_rsp", rsp_valid, 0);
        chk("rr_still_idle", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
